lcd_pattern_source: RTL and testbench

Raster-order pixel-stream generator for the LCD rectangle write path. It sits directly upstream of the `lcd` driver's `rect_pixel_write` stream. On a start pulse it latches a rectangle and a pattern selection, then emits exactly one 16-bit RGB565 pixel per accepted beat over a valid/ready handshake. Unlike a free-running pixel calculator, it tracks its own coordinates, so stalls on the consumer side can never skew the pattern.

---
 rtl/lcd_pattern_source_pkg.sv | 22 ++
 rtl/lcd_pattern_source_pixel.sv | 32 +++
 rtl/lcd_pattern_source.sv | 156 +++++++++++++++
 tb/tb_lcd_pattern_source.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pattern_source_pkg.sv
// Shared definitions for the LCD rectangle pattern source: pattern codes,
// FSM state encodings and default port widths.
package lcd_pattern_source_pkg;

    localparam int LCD_COORDINATE_WIDTH = 9;
    localparam int LCD_PIXEL_WIDTH      = 16;
    localparam int LCD_GRID_SHIFT       = 4;

    typedef enum logic [1:0] {
        LCD_PATTERN_SOLID    = 2'd0,
        LCD_PATTERN_GRID     = 2'd1,
        LCD_PATTERN_CHECKER  = 2'd2,
        LCD_PATTERN_GRADIENT = 2'd3
    } lcd_pattern_t;

    typedef enum logic [1:0] {
        LCD_STATE_IDLE   = 2'd0,
        LCD_STATE_RUN    = 2'd1,
        LCD_STATE_FINISH = 2'd2
    } lcd_state_t;

endpackage

// File: rtl/lcd_pattern_source_pixel.sv
// Combinational pattern function: (pattern, colour, rx, ry) -> RGB565 pixel.
// The gradient field packing assumes 9-bit coordinates and 16-bit pixels.
module lcd_pattern_pixel
    import lcd_pattern_source_pkg::*;
#(
    parameter int CoordinateWidth = LCD_COORDINATE_WIDTH,
    parameter int PixelWidth      = LCD_PIXEL_WIDTH,
    parameter int GridShift       = LCD_GRID_SHIFT
) (
    input  logic [1:0]                 pattern,
    input  logic [PixelWidth-1:0]      color,
    input  logic [CoordinateWidth-1:0] rx,
    input  logic [CoordinateWidth-1:0] ry,
    output logic [PixelWidth-1:0]      pixel
);

    logic [8:0] sum;

    always_comb begin
        sum   = rx + ry;
        pixel = '0;
        case (pattern)
            LCD_PATTERN_SOLID:    pixel = color;
            LCD_PATTERN_GRID:     pixel = ((rx[GridShift-1:0] == '0) || (ry[GridShift-1:0] == '0))
                                          ? {PixelWidth{1'b1}} : '0;
            LCD_PATTERN_CHECKER:  pixel = (rx[GridShift] ^ ry[GridShift]) ? color : '0;
            LCD_PATTERN_GRADIENT: pixel = {rx[7:3], ry[7:2], sum[8:4]};
            default:              pixel = '0;
        endcase
    end

endmodule

// File: rtl/lcd_pattern_source.sv
// Raster-order pattern generator feeding the LCD rectangle write stream over
// a valid/ready handshake; coordinates are tracked locally so stalls never skew it.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// RUN    | presenting pixels, advancing one coordinate per accepted beat
// FINISH | done pulse for one cycle, then back to IDLE
module lcd_pattern_source
    import lcd_pattern_source_pkg::*;
#(
    parameter int CoordinateWidth = LCD_COORDINATE_WIDTH,
    parameter int PixelWidth      = LCD_PIXEL_WIDTH,
    parameter int GridShift       = LCD_GRID_SHIFT
) (
    input  logic                       clock_48mhz,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 pattern,
    input  logic [PixelWidth-1:0]      color,
    input  logic [CoordinateWidth-1:0] rect_x0,
    input  logic [CoordinateWidth-1:0] rect_x1,
    input  logic [CoordinateWidth-1:0] rect_y0,
    input  logic [CoordinateWidth-1:0] rect_y1,
    output logic                       busy,
    output logic                       done,
    output logic [PixelWidth-1:0]      pixel_out,
    output logic                       pixel_valid,
    input  logic                       pixel_ready,
    output logic [CoordinateWidth-1:0] rel_x,
    output logic [CoordinateWidth-1:0] rel_y
);

    lcd_state_t                 state;
    logic [1:0]                 pattern_q;
    logic [PixelWidth-1:0]      color_q;
    logic [CoordinateWidth-1:0] width_q;
    logic [CoordinateWidth-1:0] height_q;

    // One extra bit keeps the borrow so x1 < x0 (or y1 < y0) is seen as empty.
    logic [CoordinateWidth:0]   width_ext;
    logic [CoordinateWidth:0]   height_ext;
    logic                       rect_empty;

    logic                       transfer;
    logic                       last_beat;
    logic [CoordinateWidth-1:0] next_x;
    logic [CoordinateWidth-1:0] next_y;
    logic [1:0]                 sel_pattern;
    logic [PixelWidth-1:0]      sel_color;
    logic [PixelWidth-1:0]      next_pixel;

    always_comb begin
        width_ext  = {1'b0, rect_x1} - {1'b0, rect_x0};
        height_ext = {1'b0, rect_y1} - {1'b0, rect_y0};
        rect_empty = width_ext[CoordinateWidth] | height_ext[CoordinateWidth];

        transfer  = pixel_valid & pixel_ready;
        last_beat = (rel_x == width_q) && (rel_y == height_q);

        next_x = '0;
        next_y = '0;
        if (state == LCD_STATE_RUN) begin
            if (rel_x == width_q) begin
                next_x = '0;
                next_y = rel_y + CoordinateWidth'(1);
            end else begin
                next_x = rel_x + CoordinateWidth'(1);
                next_y = rel_y;
            end
        end

        // In IDLE the first pixel is computed from the live inputs so it is
        // already registered when pixel_valid rises.
        sel_pattern = (state == LCD_STATE_IDLE) ? pattern : pattern_q;
        sel_color   = (state == LCD_STATE_IDLE) ? color   : color_q;
    end

    lcd_pattern_pixel #(
        .CoordinateWidth(CoordinateWidth),
        .PixelWidth     (PixelWidth),
        .GridShift      (GridShift)
    ) u_pixel (
        .pattern(sel_pattern),
        .color  (sel_color),
        .rx     (next_x),
        .ry     (next_y),
        .pixel  (next_pixel)
    );

    always_ff @(posedge clock_48mhz) begin
        if (reset) begin
            state       <= LCD_STATE_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_out   <= '0;
            rel_x       <= '0;
            rel_y       <= '0;
            pattern_q   <= '0;
            color_q     <= '0;
            width_q     <= '0;
            height_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LCD_STATE_IDLE: begin
                    if (start) begin
                        pattern_q <= pattern;
                        color_q   <= color;
                        width_q   <= width_ext[CoordinateWidth-1:0];
                        height_q  <= height_ext[CoordinateWidth-1:0];
                        rel_x     <= '0;
                        rel_y     <= '0;
                        if (rect_empty) begin
                            state <= LCD_STATE_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= LCD_STATE_RUN;
                            busy        <= 1'b1;
                            pixel_valid <= 1'b1;
                            pixel_out   <= next_pixel;
                        end
                    end
                end
                LCD_STATE_RUN: begin
                    if (abort) begin
                        state       <= LCD_STATE_IDLE;
                        busy        <= 1'b0;
                        pixel_valid <= 1'b0;
                    end else if (transfer) begin
                        if (last_beat) begin
                            state       <= LCD_STATE_FINISH;
                            busy        <= 1'b0;
                            pixel_valid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            rel_x     <= next_x;
                            rel_y     <= next_y;
                            pixel_out <= next_pixel;
                        end
                    end
                end
                LCD_STATE_FINISH: begin
                    state <= LCD_STATE_IDLE;
                end
                default: begin
                    state       <= LCD_STATE_IDLE;
                    busy        <= 1'b0;
                    pixel_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_pattern_source.sv
// Self-checking bench for lcd_pattern_source: a raster-order behavioural model
// is compared against the DUT outputs on every cycle.
module tb_lcd_pattern_source;

    logic        clock_48mhz = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] color = 16'h0;
    logic [8:0]  rect_x0 = 9'd0, rect_x1 = 9'd0, rect_y0 = 9'd0, rect_y1 = 9'd0;
    logic        busy, done, pixel_valid;
    logic [15:0] pixel_out;
    logic        pixel_ready = 1'b0;
    logic [8:0]  rel_x, rel_y;

    int checks = 0;
    int errors = 0;

    always #10 clock_48mhz = ~clock_48mhz;

    lcd_pattern_source dut (
        .clock_48mhz(clock_48mhz),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .color      (color),
        .rect_x0    (rect_x0),
        .rect_x1    (rect_x1),
        .rect_y0    (rect_y0),
        .rect_y1    (rect_y1),
        .busy       (busy),
        .done       (done),
        .pixel_out  (pixel_out),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .rel_x      (rel_x),
        .rel_y      (rel_y)
    );

    // Pattern rules in plain integer arithmetic.
    function automatic int model_pixel(int pat, int col, int rx, int ry);
        case (pat)
            0:       return col;
            1:       return ((rx % 16 == 0) || (ry % 16 == 0)) ? 'hFFFF : 0;
            2:       return (((rx / 16) + (ry / 16)) % 2 == 1) ? col : 0;
            default: return ((rx / 8) % 32) * 2048 + ((ry / 4) % 64) * 32 + ((rx + ry) % 512) / 16;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the DUT outputs must be in the current cycle.
    bit armed = 0;
    bit m_run = 0;
    bit m_done = 0;
    bit m_zero = 0;
    int mx, my, mw, mh, mpat, mcol;
    int beats = 0;

    always @(negedge clock_48mhz) begin
        if (armed) begin
            chk("pixel_valid", 32'(pixel_valid), 32'(m_run));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            if (m_run) begin
                chk("pixel_out", 32'(pixel_out), 32'(model_pixel(mpat, mcol, mx, my)));
                chk("rel_x", 32'(rel_x), 32'(mx));
                chk("rel_y", 32'(rel_y), 32'(my));
            end else if (m_zero) begin
                chk("reset_pixel_out", 32'(pixel_out), 32'd0);
                chk("reset_rel_x", 32'(rel_x), 32'd0);
                chk("reset_rel_y", 32'(rel_y), 32'd0);
            end
        end
        // Predict the next cycle from the inputs presented for the coming edge.
        if (reset) begin
            armed  = 1;
            m_run  = 0;
            m_done = 0;
            m_zero = 1;
        end else if (m_run) begin
            if (abort) begin
                m_run = 0;
            end else if (pixel_ready) begin
                beats++;
                if (mx == mw && my == mh) begin
                    m_run  = 0;
                    m_done = 1;
                end else if (mx == mw) begin
                    mx = 0;
                    my++;
                end else begin
                    mx++;
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            m_zero = 0;
            mw     = int'(rect_x1) - int'(rect_x0);
            mh     = int'(rect_y1) - int'(rect_y0);
            mpat   = int'(pattern);
            mcol   = int'(color);
            if (mw < 0 || mh < 0) begin
                m_done = 1;
            end else begin
                m_run = 1;
                mx    = 0;
                my    = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clock_48mhz);
        #1;
    endtask

    task automatic launch(input int x0, input int x1, input int y0, input int y1,
                          input int pat, input int col);
        rect_x0 = 9'(x0);
        rect_x1 = 9'(x1);
        rect_y0 = 9'(y0);
        rect_y1 = 9'(y1);
        pattern = 2'(pat);
        color   = 16'(col);
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    // ready_mode 0: held high, 1: random. event_after > 0 fires an action
    // (1 abort, 2 stray start, 3 reset) once that many beats were accepted.
    task automatic drain(input int ready_mode, input int event_after, input int action);
        int n = 0;
        int b0 = beats;
        bit fired = 0;
        while ((m_run || m_done) && n < 20000) begin
            pixel_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (event_after > 0 && !fired && (beats - b0) >= event_after) begin
                fired = 1;
                if (action == 1) abort = 1'b1;
                if (action == 3) reset = 1'b1;
                if (action == 2) begin
                    rect_x0 = 9'd3;  rect_x1 = 9'd7;
                    rect_y0 = 9'd1;  rect_y1 = 9'd2;
                    pattern = 2'd0;  color   = 16'h5A5A;
                    start   = 1'b1;
                end
            end
            cyc();
            abort = 1'b0;
            reset = 1'b0;
            start = 1'b0;
            n++;
        end
        if (n >= 20000) begin
            errors++;
            $display("FAIL drain_timeout actual %0d cycles expected completion", n);
        end
        pixel_ready = 1'b0;
        cyc();
    endtask

    initial begin
        int b;
        // Pin the model against hand-derived values.
        chk("model_grad_8_4", 32'(model_pixel(3, 0, 8, 4)), 32'h0820);
        chk("model_grad_16_8", 32'(model_pixel(3, 0, 16, 8)), 32'h1041);
        chk("model_grid_16_5", 32'(model_pixel(1, 0, 16, 5)), 32'hFFFF);
        chk("model_grid_5_5", 32'(model_pixel(1, 0, 5, 5)), 32'h0000);
        chk("model_checker_16_0", 32'(model_pixel(2, 'hABCD, 16, 0)), 32'hABCD);
        chk("model_checker_16_16", 32'(model_pixel(2, 'hABCD, 16, 16)), 32'h0000);
        chk("model_count_241x241", 32'((360 - 120 + 1) * (280 - 40 + 1)), 32'd58081);

        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Small solid rectangle, consumer always ready.
        b = beats;
        launch(0, 3, 0, 1, 0, 'h1234);
        drain(0, 0, 0);
        chk("solid_beats", 32'(beats - b), 32'd8);

        // Grid with random back-pressure.
        b = beats;
        launch(0, 79, 0, 47, 1, 'h0000);
        drain(1, 0, 0);
        chk("grid_beats", 32'(beats - b), 32'd3840);

        // Empty rectangle.
        b = beats;
        launch(10, 9, 0, 5, 0, 'h1111);
        drain(1, 0, 0);
        chk("empty_beats", 32'(beats - b), 32'd0);

        // Checker, aborted after 1000 beats, then restarted.
        b = beats;
        launch(120, 360, 40, 280, 2, 'hF00F);
        drain(1, 1000, 1);
        chk("abort_beats", 32'(beats - b), 32'd1000);
        b = beats;
        launch(0, 20, 0, 20, 2, 'h0F0F);
        drain(0, 0, 0);
        chk("restart_beats", 32'(beats - b), 32'd441);

        // Stray start mid-run must not disturb the run.
        b = beats;
        launch(100, 130, 20, 50, 3, 'h0000);
        drain(1, 200, 2);
        chk("stray_start_beats", 32'(beats - b), 32'd961);

        // Reset mid-run, then a gradient run covering (8,4).
        launch(0, 50, 0, 50, 1, 'h0000);
        drain(1, 300, 3);
        b = beats;
        launch(0, 15, 0, 7, 3, 'h0000);
        drain(1, 0, 0);
        chk("gradient_beats", 32'(beats - b), 32'd128);

        // Random rectangles, patterns and occasional aborts.
        for (int i = 0; i < 20; i++) begin
            int x0 = $urandom_range(0, 40);
            int y0 = $urandom_range(0, 40);
            int x1 = $urandom_range(0, 70);
            int y1 = $urandom_range(0, 60);
            int ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 100) : 0;
            launch(x0, x1, y0, y1, $urandom_range(0, 3), $urandom_range(0, 65535));
            drain(1, ab, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
